// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO onto a valid/ready stream with packet framing.
// A 2-entry skid buffer with credit-gated reads hides the FIFO's one-cycle read latency.
module fifo_stream_reader #(
    parameter int DATA_W  = 32,
    parameter int PKT_LEN = 4,
    parameter int MIN_GAP = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [31:0]       words_sent,
    output logic              busy
);
    localparam int PKT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
    localparam logic [PKT_W-1:0] PKT_MAX = PKT_W'(PKT_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(MIN_GAP);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_buf0;
    logic [DATA_W-1:0] r_buf1;
    logic [1:0]        r_occ;
    logic              r_inflight;
    logic [PKT_W-1:0]  r_pkt_cnt;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [31:0]       r_words_sent;

    logic w_pop;
    logic w_push;
    logic w_gap_ok;
    logic w_credit;

    assign w_pop    = (r_occ != 2'd0) && m_ready;
    assign w_push   = r_inflight;
    assign w_gap_ok = (r_gap_cnt == '0);
    // Room check: words held plus the word still arriving, less the word leaving this cycle.
    assign w_credit = ({1'b0, r_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});

    // enable gates reads directly so a drop stops reads in the same cycle.
    assign fifo_rd_en = !rst && (r_state == RUN) && enable && !fifo_empty && w_gap_ok && w_credit;

    assign m_valid    = (r_occ != 2'd0);
    assign m_data     = r_buf0;
    assign m_last     = m_valid && (r_pkt_cnt == PKT_MAX);
    assign words_sent = r_words_sent;
    assign busy       = (r_state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_buf0       <= '0;
            r_buf1       <= '0;
            r_occ        <= '0;
            r_inflight   <= 1'b0;
            r_pkt_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_words_sent <= '0;
        end else begin
            r_inflight <= fifo_rd_en;

            if (fifo_rd_en) begin
                r_gap_cnt <= GAP_LD;
            end else if (!w_gap_ok) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end

            // Buffer head is r_buf0; a pop shifts r_buf1 forward.
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_buf0 <= fifo_rd_data;
                    else               r_buf1 <= fifo_rd_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf0 <= fifo_rd_data;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= fifo_rd_data;
                    end
                end
                default: ;
            endcase

            if (w_pop) begin
                r_words_sent <= r_words_sent + 32'd1;
                if (r_pkt_cnt == PKT_MAX) r_pkt_cnt <= '0;
                else                      r_pkt_cnt <= r_pkt_cnt + PKT_W'(1);
            end

            case (r_state)
                IDLE:    if (enable) r_state <= RUN;
                RUN:     if (!enable) r_state <= DRAIN;
                DRAIN: begin
                    if (enable)                             r_state <= RUN;
                    else if (r_occ == 2'd0 && !r_inflight)  r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: two instances (MIN_GAP 0 / PKT_LEN 4 and MIN_GAP 2 / PKT_LEN 3)
// driven through a behavioural FIFO, with a read-order scoreboard, directed sequences and random traffic.
module tb_fifo_stream_reader;
    localparam int NCH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en     [NCH];
    logic        rdy    [NCH];
    logic        fempty [NCH];
    logic [31:0] frdata [NCH];
    logic        rden   [NCH];
    logic        mvalid [NCH];
    logic [31:0] mdata  [NCH];
    logic        mlast  [NCH];
    logic [31:0] wsent  [NCH];
    logic        busy   [NCH];

    always #5 clk = ~clk;

    fifo_stream_reader #(.DATA_W(32), .PKT_LEN(4), .MIN_GAP(0)) u_dut0 (
        .clk(clk), .rst(rst), .enable(en[0]), .fifo_empty(fempty[0]), .fifo_rd_en(rden[0]),
        .fifo_rd_data(frdata[0]), .m_valid(mvalid[0]), .m_ready(rdy[0]), .m_data(mdata[0]),
        .m_last(mlast[0]), .words_sent(wsent[0]), .busy(busy[0]));

    fifo_stream_reader #(.DATA_W(32), .PKT_LEN(3), .MIN_GAP(2)) u_dut1 (
        .clk(clk), .rst(rst), .enable(en[1]), .fifo_empty(fempty[1]), .fifo_rd_en(rden[1]),
        .fifo_rd_data(frdata[1]), .m_valid(mvalid[1]), .m_ready(rdy[1]), .m_data(mdata[1]),
        .m_last(mlast[1]), .words_sent(wsent[1]), .busy(busy[1]));

    function automatic int pkt_of(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic int gap_of(input int k);
        return (k == 0) ? 0 : 2;
    endfunction

    // Behavioural FIFO, scoreboard of words read out of it, and per-cycle observations.
    logic [31:0] fmem [NCH][16];
    int unsigned fhd [NCH], fcnt [NCH];
    logic [31:0] sb [NCH][64];
    int unsigned sbw [NCH], sbr [NCH], npop [NCH], nrd [NCH];
    int          last_rd [NCH];
    int          cyc;
    logic        rec_rd [NCH], rec_wr [NCH], rec_pop [NCH];
    logic        obs_v [NCH];
    logic [31:0] obs_d [NCH];
    logic        hold_v [NCH], hold_l [NCH];
    logic [31:0] hold_d [NCH];
    logic        wr_req [NCH];
    logic [31:0] wr_next [NCH];
    logic        prev_rst;
    int unsigned n_chk, n_err;

    typedef struct {
        logic        en;
        logic        rdy;
        logic        rd;
        logic        v;
        logic [31:0] d;
        logic        l;
        logic        b;
    } vec_t;
    vec_t tbl [20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic monitor(input int k);
        logic pop;
        int   pk;
        int   outstanding;
        pk  = pkt_of(k);
        pop = mvalid[k] & rdy[k];
        obs_v[k]  = mvalid[k];
        obs_d[k]  = mdata[k];
        rec_rd[k] = rden[k];
        rec_wr[k] = 1'b0;
        rec_pop[k] = 1'b0;
        if (rst) begin
            if (prev_rst) begin
                chk($sformatf("ch%0d reset rd_en", k), 32'(rden[k]), 32'd0);
                chk($sformatf("ch%0d reset m_valid", k), 32'(mvalid[k]), 32'd0);
                chk($sformatf("ch%0d reset m_data", k), mdata[k], 32'd0);
                chk($sformatf("ch%0d reset m_last", k), 32'(mlast[k]), 32'd0);
                chk($sformatf("ch%0d reset words_sent", k), wsent[k], 32'd0);
                chk($sformatf("ch%0d reset busy", k), 32'(busy[k]), 32'd0);
            end
            return;
        end
        chk($sformatf("ch%0d words_sent", k), wsent[k], npop[k]);
        if (hold_v[k]) begin
            chk($sformatf("ch%0d stall m_valid", k), 32'(mvalid[k]), 32'd1);
            chk($sformatf("ch%0d stall m_data", k), mdata[k], hold_d[k]);
            chk($sformatf("ch%0d stall m_last", k), 32'(mlast[k]), 32'(hold_l[k]));
        end
        if (mvalid[k]) begin
            if (sbr[k] == sbw[k]) begin
                chk($sformatf("ch%0d spurious m_valid", k), 32'(mvalid[k]), 32'd0);
            end else begin
                chk($sformatf("ch%0d m_data", k), mdata[k], sb[k][sbr[k] % 64]);
                chk($sformatf("ch%0d m_last", k), 32'(mlast[k]),
                    32'((npop[k] % pk) == pk - 1));
            end
        end
        if (rden[k]) begin
            chk($sformatf("ch%0d rd_en on empty", k), 32'(fempty[k]), 32'd0);
            chk($sformatf("ch%0d rd_en while disabled", k), 32'(en[k]), 32'd1);
            chk($sformatf("ch%0d rd_en spacing", k), 32'((cyc - last_rd[k]) > gap_of(k)), 32'd1);
        end
        outstanding = int'(nrd[k]) + int'(rden[k]) - int'(npop[k]) - int'(pop);
        chk($sformatf("ch%0d buffer occupancy<=2", k), 32'(outstanding <= 2), 32'd1);
        rec_pop[k] = pop;
        rec_wr[k]  = wr_req[k] && !rden[k] && (fcnt[k] < 16);
        hold_v[k]  = mvalid[k] & !rdy[k];
        hold_d[k]  = mdata[k];
        hold_l[k]  = mlast[k];
    endtask

    task automatic commit(input int k, input logic was_rst);
        if (rec_rd[k] && fcnt[k] != 0) begin
            frdata[k] = fmem[k][fhd[k]];
            sb[k][sbw[k] % 64] = frdata[k];
            sbw[k]++;
            fhd[k] = (fhd[k] + 1) % 16;
            fcnt[k]--;
            nrd[k]++;
            last_rd[k] = cyc;
        end else begin
            frdata[k] = '0;
        end
        if (rec_wr[k]) begin
            fmem[k][(fhd[k] + fcnt[k]) % 16] = wr_next[k];
            wr_next[k]++;
            fcnt[k]++;
        end
        if (rec_pop[k]) begin
            sbr[k]++;
            npop[k]++;
        end
        if (was_rst) begin
            sbr[k] = 0; sbw[k] = 0; npop[k] = 0; nrd[k] = 0;
            hold_v[k] = 1'b0;
            last_rd[k] = -1000;
        end
        fempty[k] = (fcnt[k] == 0);
    endtask

    // Called just after a clock edge; samples mid-cycle, then applies FIFO effects after the next edge.
    task automatic tick();
        logic r;
        #1;
        for (int k = 0; k < NCH; k++) monitor(k);
        r = rst;
        @(posedge clk);
        #1;
        for (int k = 0; k < NCH; k++) commit(k, r);
        prev_rst = r;
        cyc++;
    endtask

    task automatic preload(input int k, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            fmem[k][(fhd[k] + fcnt[k]) % 16] = base + 32'(i);
            fcnt[k]++;
        end
        fempty[k] = (fcnt[k] == 0);
    endtask

    task automatic flush(input int k);
        fcnt[k] = 0;
        fempty[k] = 1'b1;
    endtask

    task automatic wait_idle(input int k, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            if (!busy[k]) break;
            tick();
        end
        chk(nm, 32'(busy[k]), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        int first_rd, first_v, end_v, n0, nw, nr0;
        logic [31:0] exp_first;

        n_chk = 0; n_err = 0; cyc = 0; prev_rst = 1'b1; rst = 1'b1;
        for (int k = 0; k < NCH; k++) begin
            en[k] = 1'b0; rdy[k] = 1'b0; wr_req[k] = 1'b0; fempty[k] = 1'b1; frdata[k] = '0;
            fhd[k] = 0; fcnt[k] = 0; sbw[k] = 0; sbr[k] = 0; npop[k] = 0; nrd[k] = 0;
            last_rd[k] = -1000; hold_v[k] = 1'b0; hold_d[k] = '0; hold_l[k] = 1'b0;
            rec_rd[k] = 1'b0; rec_wr[k] = 1'b0; rec_pop[k] = 1'b0;
            obs_v[k] = 1'b0; obs_d[k] = '0; wr_next[k] = 32'h0;
        end

        // Reset held two cycles with enable high and data waiting in the FIFO.
        preload(0, 32'hDEAD0000, 4);
        preload(1, 32'hBEEF0000, 4);
        en[0] = 1'b1; en[1] = 1'b1;
        @(posedge clk); #1;
        tick(); tick();
        flush(0); flush(1);
        en[0] = 1'b0; en[1] = 1'b0; rst = 1'b0;
        tick();

        // Free-flowing burst: latency, back-to-back delivery, framing.
        preload(0, 32'h100, 8);
        en[0] = 1'b1; rdy[0] = 1'b1;
        first_rd = -1; first_v = -1; end_v = -1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rec_rd[0] && first_rd < 0) first_rd = cyc - 1;
            if (obs_v[0] && first_v < 0) first_v = cyc - 1;
            if (!obs_v[0] && first_v >= 0 && end_v < 0) end_v = cyc - 1;
        end
        chk("burst rd_en to m_valid latency", 32'(first_v - first_rd), 32'd2);
        chk("burst consecutive valid cycles", 32'(end_v - first_v), 32'd8);
        chk("burst words_sent", wsent[0], 32'd8);
        en[0] = 1'b0;
        wait_idle(0, 10, "burst return to idle");

        // Cycle-exact backpressure table: 6 stalled cycles after first m_valid.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1};
        for (int i = 4; i <= 8; i++) tbl[i] = tbl[3];
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h101, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h102, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h103, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h105, 1'b0, 1'b1};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h106, 1'b0, 1'b1};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h107, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b1};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0};
        preload(0, 32'h100, 8);
        for (int i = 0; i < 20; i++) begin
            en[0] = tbl[i].en; rdy[0] = tbl[i].rdy;
            #1;
            chk($sformatf("table row %0d rd_en", i), 32'(rden[0]), 32'(tbl[i].rd));
            chk($sformatf("table row %0d m_valid", i), 32'(mvalid[0]), 32'(tbl[i].v));
            if (tbl[i].v) begin
                chk($sformatf("table row %0d m_data", i), mdata[0], tbl[i].d);
                chk($sformatf("table row %0d m_last", i), 32'(mlast[0]), 32'(tbl[i].l));
            end
            chk($sformatf("table row %0d busy", i), 32'(busy[0]), 32'(tbl[i].b));
            tick();
        end

        // Enable dropped right after the first read: only the in-flight word comes out.
        preload(0, 32'h400, 8);
        en[0] = 1'b1; rdy[0] = 1'b1;
        n0 = int'(npop[0]);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rec_rd[0]) break;
        end
        chk("enable drop saw first rd_en", 32'(rec_rd[0]), 32'd1);
        en[0] = 1'b0;
        wait_idle(0, 10, "enable drop return to idle");
        chk("enable drop words emitted", 32'(int'(npop[0]) - n0), 32'd1);
        chk("enable drop FIFO retains words", fcnt[0], 32'd7);

        // Reset one cycle after a read, mid-packet, with words buffered.
        flush(0);
        preload(0, 32'h600, 12);
        en[0] = 1'b1; rdy[0] = 1'b1;
        n0 = int'(npop[0]);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (int'(npop[0]) >= n0 + 2 && rec_rd[0]) break;
        end
        chk("mid-stream reset saw rd_en", 32'(rec_rd[0]), 32'd1);
        rst = 1'b1; en[0] = 1'b0; rdy[0] = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("post-reset m_valid", 32'(mvalid[0]), 32'd0);
        chk("post-reset words_sent", wsent[0], 32'd0);
        exp_first = fmem[0][fhd[0]];
        en[0] = 1'b1; rdy[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_v[0]) break;
        end
        chk("post-reset first word", obs_d[0], exp_first);
        for (int i = 0; i < 8; i++) tick();
        en[0] = 1'b0;
        wait_idle(0, 10, "post-reset return to idle");
        flush(0);

        // Gapped reads on channel 1 with a writer pushing every cycle.
        flush(1);
        preload(1, 32'h500, 2);
        wr_next[1] = 32'h502; wr_req[1] = 1'b1; en[1] = 1'b1; rdy[1] = 1'b1;
        nr0 = int'(nrd[1]); n0 = int'(npop[1]); nw = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (rec_wr[1]) nw++;
        end
        chk("gap reads issued", 32'(int'(nrd[1]) - nr0 >= 15), 32'd1);
        chk("gap words delivered", 32'(int'(npop[1]) - n0 >= 15), 32'd1);
        chk("gap writer accepted", 32'(nw >= 14), 32'd1);
        wr_req[1] = 1'b0; en[1] = 1'b0;
        wait_idle(1, 10, "gap return to idle");

        // Random traffic on both channels.
        for (int k = 0; k < NCH; k++) begin
            en[k] = 1'b1;
            wr_next[k] = 32'h7000_0000 + 32'(k) * 32'h0100_0000;
        end
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < NCH; k++) begin
                if ($urandom_range(15) == 0) en[k] = !en[k];
                rdy[k]    = ($urandom_range(99) < 65);
                wr_req[k] = ($urandom_range(1) == 1);
            end
            tick();
        end
        for (int k = 0; k < NCH; k++) begin
            wr_req[k] = 1'b0; en[k] = 1'b0; rdy[k] = 1'b1;
        end
        wait_idle(0, 20, "random ch0 drain");
        wait_idle(1, 20, "random ch1 drain");
        chk("random ch0 all reads delivered", sbw[0] - sbr[0], 32'd0);
        chk("random ch1 all reads delivered", sbw[1] - sbr[1], 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
